// File: rtl/mesif_pkg.sv
// MESIF controller shared codes and types.
// State, op, bus and snoop encodings.
package mesif_pkg;

  typedef enum logic [2:0] {
    ST_M = 3'd0,
    ST_E = 3'd1,
    ST_S = 3'd2,
    ST_I = 3'd3,
    ST_F = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_EVICT,
    S_BUS,
    S_CLEAR,
    S_DONE
  } fsm_t;

  localparam logic [3:0] OP_RD   = 4'd0;
  localparam logic [3:0] OP_WR   = 4'd1;
  localparam logic [3:0] OP_IF   = 4'd2;
  localparam logic [3:0] OP_SINV = 4'd3;
  localparam logic [3:0] OP_SRD  = 4'd4;
  localparam logic [3:0] OP_SWR  = 4'd5;
  localparam logic [3:0] OP_SRFO = 4'd6;
  localparam logic [3:0] OP_CLR  = 4'd8;
  localparam logic [3:0] OP_PRN  = 4'd9;

  localparam logic [2:0] BUS_NOP   = 3'd0;
  localparam logic [2:0] BUS_READ  = 3'd1;
  localparam logic [2:0] BUS_WRITE = 3'd2;
  localparam logic [2:0] BUS_INV   = 3'd3;
  localparam logic [2:0] BUS_RFO   = 3'd4;

  localparam logic [1:0] SNP_HIT   = 2'd0;
  localparam logic [1:0] SNP_HITM  = 2'd1;
  localparam logic [1:0] SNP_NOHIT = 2'd3;

  function automatic logic is_cpu_rd(
    input logic [3:0] op
  );
    return (op == OP_RD) || (op == OP_IF);
  endfunction

  function automatic logic is_cpu(
    input logic [3:0] op
  );
    return is_cpu_rd(op) || (op == OP_WR);
  endfunction

endpackage

// File: rtl/mesif_next_state.sv
// MESIF transition table: next state,
// bus operation and snoop response.
module mesif_next_state
  import mesif_pkg::*;
(
  input  logic [3:0] i_op,
  input  state_t     i_cur,
  input  logic       i_hit,
  input  logic [1:0] i_snoop,
  output state_t     o_next,
  output logic [2:0] o_bus,
  output logic [1:0] o_snoop
);

  logic w_m;
  logic w_sf;

  assign w_m  = (i_cur == ST_M);
  assign w_sf = (i_cur == ST_S) || (i_cur == ST_F);

  // decode one operation against the current line state
  always_comb begin
    o_next  = i_hit ? i_cur : ST_I;
    o_bus   = BUS_NOP;
    o_snoop = SNP_NOHIT;
    unique case (1'b1)
      is_cpu_rd(i_op): begin
        if (!i_hit) begin
          o_bus = BUS_READ;
          if (i_snoop == SNP_HIT ||
              i_snoop == SNP_HITM)
            o_next = ST_F;
          else
            o_next = ST_E;
        end
      end
      (i_op == OP_WR): begin
        o_next = ST_M;
        if (!i_hit)
          o_bus = BUS_RFO;
        else if (w_sf)
          o_bus = BUS_INV;
      end
      (i_op == OP_SRD): begin
        if (i_hit) begin
          o_next  = ST_S;
          o_snoop = w_m ? SNP_HITM : SNP_HIT;
          if (w_m) o_bus = BUS_WRITE;
        end
      end
      (i_op == OP_SRFO): begin
        if (i_hit) begin
          o_next  = ST_I;
          o_snoop = w_m ? SNP_HITM : SNP_HIT;
          if (w_m) o_bus = BUS_WRITE;
        end
      end
      (i_op == OP_SINV): begin
        if (i_hit && w_sf) begin
          o_next  = ST_I;
          o_snoop = SNP_HIT;
        end
      end
      (i_op == OP_CLR): begin
        o_next = ST_I;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/mesif_ctrl.sv
// Set-associative MESIF coherence controller:
// tag/state arrays, victim pick, FSM, bus handshake.
module mesif_ctrl
  import mesif_pkg::*;
#(
  parameter int TAG_BITS   = 12,
  parameter int INDEX_BITS = 4,
  parameter int WAYS       = 4,
  parameter int WAY_BITS   =
    (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [TAG_BITS-1:0]   req_tag,
  input  logic [INDEX_BITS-1:0] req_index,
  input  logic [WAY_BITS-1:0]   lru_way,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic [2:0]            bus_op,
  output logic [TAG_BITS-1:0]   bus_tag,
  output logic [INDEX_BITS-1:0] bus_index,
  input  logic [1:0]            snoop_in,
  output logic                  done,
  output logic                  hit,
  output logic [WAY_BITS-1:0]   hit_way,
  output logic [2:0]            line_state,
  output logic [1:0]            snoop_out
);

  localparam int SETS = 1 << INDEX_BITS;

  fsm_t r_state;
  fsm_t w_nxt;

  logic [SETS-1:0][WAYS-1:0][2:0] r_st;
  logic [SETS-1:0][WAYS-1:0][TAG_BITS-1:0] r_tagm;

  logic [3:0]            r_op;
  logic [TAG_BITS-1:0]   r_tag;
  logic [INDEX_BITS-1:0] r_idx;
  logic [INDEX_BITS-1:0] r_cnt;
  logic                  r_hit;
  state_t                r_cur;
  logic [WAY_BITS-1:0]   r_way;

  logic                  r_bus_valid;
  logic [2:0]            r_bus_op;
  logic [TAG_BITS-1:0]   r_bus_tag;
  logic [INDEX_BITS-1:0] r_bus_index;
  logic                  r_hit_o;
  logic [WAY_BITS-1:0]   r_hit_way;
  logic [2:0]            r_line_state;
  logic [1:0]            r_snoop_out;

  logic                w_hit;
  logic [WAY_BITS-1:0] w_hit_way;
  state_t              w_cur;
  logic                w_inv;
  logic [WAY_BITS-1:0] w_victim;
  state_t              w_vic_st;
  logic [TAG_BITS-1:0] w_vic_tag;
  logic                w_lk;
  logic                w_h;
  state_t              w_c;
  logic [WAY_BITS-1:0] w_way;
  logic                w_fill;
  logic                w_evict;
  logic                w_commit;
  state_t              w_ns;
  logic [2:0]          w_bus;
  logic [1:0]          w_snp;

  // tag match and lowest-invalid victim search
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_cur     = ST_I;
    w_inv     = 1'b0;
    w_victim  = lru_way;
    for (int i = 0; i < WAYS; i++) begin
      if (!w_hit &&
          r_st[r_idx][i] != ST_I &&
          r_tagm[r_idx][i] == r_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_BITS'(i);
        w_cur     = state_t'(r_st[r_idx][i]);
      end
      if (!w_inv && r_st[r_idx][i] == ST_I) begin
        w_inv    = 1'b1;
        w_victim = WAY_BITS'(i);
      end
    end
  end

  assign w_vic_st  = state_t'(r_st[r_idx][w_victim]);
  assign w_vic_tag = r_tagm[r_idx][w_victim];

  assign w_lk   = (r_state == S_LOOKUP);
  assign w_h    = w_lk ? w_hit : r_hit;
  assign w_c    = w_lk ? w_cur : r_cur;
  assign w_way  = !w_lk ? r_way :
                  (w_hit ? w_hit_way : w_victim);
  assign w_fill = !w_h && is_cpu(r_op);
  assign w_evict = w_fill && (w_vic_st == ST_M);
  assign w_commit = (w_nxt == S_DONE) &&
                    (r_state != S_CLEAR) &&
                    (w_h || w_fill);

  mesif_next_state u_ns (
    .i_op    (r_op),
    .i_cur   (w_c),
    .i_hit   (w_h),
    .i_snoop (snoop_in),
    .o_next  (w_ns),
    .o_bus   (w_bus),
    .o_snoop (w_snp)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  // FSM next-state decode
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (req_valid) w_nxt = S_LOOKUP;
      S_LOOKUP: begin
        if (r_op == OP_CLR)       w_nxt = S_CLEAR;
        else if (w_evict)         w_nxt = S_EVICT;
        else if (w_bus != BUS_NOP) w_nxt = S_BUS;
        else                      w_nxt = S_DONE;
      end
      S_EVICT:
        if (bus_ready) w_nxt = S_BUS;
      S_BUS:
        if (bus_ready) w_nxt = S_DONE;
      S_CLEAR:
        if (&r_cnt) w_nxt = S_DONE;
      S_DONE:
        w_nxt = S_IDLE;
      default:
        w_nxt = S_IDLE;
    endcase
  end

  // request capture, bus fields and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op         <= '0;
      r_tag        <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_hit        <= 1'b0;
      r_cur        <= ST_I;
      r_way        <= '0;
      r_bus_valid  <= 1'b0;
      r_bus_op     <= BUS_NOP;
      r_bus_tag    <= '0;
      r_bus_index  <= '0;
      r_hit_o      <= 1'b0;
      r_hit_way    <= '0;
      r_line_state <= ST_I;
      r_snoop_out  <= SNP_NOHIT;
    end else begin
      if (r_state == S_IDLE && req_valid) begin
        r_op  <= req_op;
        r_tag <= req_tag;
        r_idx <= req_index;
      end
      if (r_state == S_LOOKUP) begin
        r_hit <= w_hit;
        r_cur <= w_cur;
        r_way <= w_way;
        r_cnt <= '0;
        if (w_nxt == S_EVICT) begin
          r_bus_valid <= 1'b1;
          r_bus_op    <= BUS_WRITE;
          r_bus_tag   <= w_vic_tag;
          r_bus_index <= r_idx;
        end else if (w_nxt == S_BUS) begin
          r_bus_valid <= 1'b1;
          r_bus_op    <= w_bus;
          r_bus_tag   <= r_tag;
          r_bus_index <= r_idx;
        end
      end
      if (r_state == S_EVICT && bus_ready) begin
        r_bus_op  <= w_bus;
        r_bus_tag <= r_tag;
      end
      if (r_state == S_BUS && bus_ready) begin
        r_bus_valid <= 1'b0;
        r_bus_op    <= BUS_NOP;
      end
      if (r_state == S_CLEAR)
        r_cnt <= r_cnt + 1'b1;
      if (w_nxt == S_DONE) begin
        r_hit_o      <= w_h;
        r_hit_way    <= w_way;
        r_line_state <= w_ns;
        r_snoop_out  <= w_snp;
      end
    end
  end

  // state array: reset, clear walk, completion commit
  always_ff @(posedge clk) begin
    if (rst)
      r_st <= {(SETS*WAYS){ST_I}};
    else if (r_state == S_CLEAR)
      r_st[r_cnt] <= {WAYS{ST_I}};
    else if (w_commit)
      r_st[r_idx][w_way] <= w_ns;
  end

  // tag array: written only by a fill
  always_ff @(posedge clk) begin
    if (!rst && w_commit && w_fill)
      r_tagm[r_idx][w_way] <= r_tag;
  end

  assign req_ready  = (r_state == S_IDLE);
  assign done       = (r_state == S_DONE);
  assign bus_valid  = r_bus_valid;
  assign bus_op     = r_bus_op;
  assign bus_tag    = r_bus_tag;
  assign bus_index  = r_bus_index;
  assign hit        = r_hit_o;
  assign hit_way    = r_hit_way;
  assign line_state = r_line_state;
  assign snoop_out  = r_snoop_out;

endmodule

// File: tb/tb_mesif_ctrl.sv
// Directed bench for mesif_ctrl.
// Scenario tasks with inline checks.
module tb_mesif_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [11:0] req_tag;
  logic [3:0]  req_index;
  logic [1:0]  lru_way;
  logic        bus_valid;
  logic        bus_ready;
  logic [2:0]  bus_op;
  logic [11:0] bus_tag;
  logic [3:0]  bus_index;
  logic [1:0]  snoop_in;
  logic        done;
  logic        hit;
  logic [1:0]  hit_way;
  logic [2:0]  line_state;
  logic [1:0]  snoop_out;

  int total;
  int bad;

  mesif_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_tag    (req_tag),
    .req_index  (req_index),
    .lru_way    (lru_way),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_op     (bus_op),
    .bus_tag    (bus_tag),
    .bus_index  (bus_index),
    .snoop_in   (snoop_in),
    .done       (done),
    .hit        (hit),
    .hit_way    (hit_way),
    .line_state (line_state),
    .snoop_out  (snoop_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic [3:0]  op,
    input logic [11:0] tg,
    input logic [3:0]  ix,
    input logic [1:0]  lru
  );
    for (int i = 0; i < 40; i++) begin
      if (req_ready) break;
      tick();
    end
    req_valid = 1'b1;
    req_op    = op;
    req_tag   = tg;
    req_index = ix;
    lru_way   = lru;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_bus(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_op(
    input  logic [3:0]  op,
    input  logic [11:0] tg,
    input  logic [3:0]  ix,
    input  logic [1:0]  lru,
    input  logic [1:0]  snp,
    output logic        ok,
    output logic        h,
    output logic [2:0]  ls,
    output logic [1:0]  so
  );
    ok = 1'b0; h = 1'b0; ls = '0; so = '0;
    send(op, tg, ix, lru);
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        ok = 1'b1;
        h  = hit;
        ls = line_state;
        so = snoop_out;
        break;
      end
      bus_ready = bus_valid;
      snoop_in  = snp;
      tick();
    end
    bus_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [26:0] got;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    got = {req_ready, bus_valid, bus_op,
           bus_tag, bus_index, done};
    total++;
    if (got !== {1'b1, 1'b0, 3'd0, 12'd0, 4'd0, 1'b0})
      begin bad++; $display("FAIL reset_bus got=%h", got); end
    total++;
    if ({hit, hit_way, line_state, snoop_out} !==
        {1'b0, 2'd0, 3'd3, 2'd3}) begin
      bad++;
      $display("FAIL reset_res got=%b%b %0d %0d want 0 0 3 3",
               hit, hit_way, line_state, snoop_out);
    end
  endtask

  task automatic test_read_miss();
    logic ok;
    send(4'd0, 12'h123, 4'd1, 2'd0);
    tick();
    total++;
    if ({bus_valid, bus_op, bus_tag, bus_index} !==
        {1'b1, 3'd1, 12'h123, 4'd1}) begin
      bad++;
      $display("FAIL rd_miss_bus got v=%b op=%0d t=%h i=%0d want 1 1 123 1",
               bus_valid, bus_op, bus_tag, bus_index);
    end
    bus_ready = 1'b1;
    snoop_in  = 2'd3;
    tick();
    bus_ready = 1'b0;
    wait_done(ok);
    total++;
    if (!ok || {hit, line_state, snoop_out} !== {1'b0, 3'd1, 2'd3})
      begin
      bad++;
      $display("FAIL rd_miss_done ok=%b h=%b ls=%0d so=%0d want 1 0 1 3",
               ok, hit, line_state, snoop_out);
    end
    send(4'd0, 12'h123, 4'd1, 2'd0);
    tick();
    total++;
    if ({done, bus_valid, hit, hit_way, line_state} !==
        {1'b1, 1'b0, 1'b1, 2'd0, 3'd1}) begin
      bad++;
      $display("FAIL rd_hit_lat d=%b v=%b h=%b w=%0d ls=%0d want 1 0 1 0 1",
               done, bus_valid, hit, hit_way, line_state);
    end
  endtask

  task automatic test_write_evict();
    logic ok, h;
    logic [2:0] ls;
    logic [1:0] so;
    logic [11:0] tags [4];
    int fills;
    tags = '{12'h0A0, 12'h0A1, 12'h0AB, 12'h0A3};
    fills = 0;
    for (int k = 0; k < 4; k++) begin
      do_op(4'd0, tags[k], 4'd2, 2'd0, 2'd3, ok, h, ls, so);
      if (ok && !h && ls == 3'd1) fills++;
    end
    total++;
    if (fills != 4)
      begin bad++; $display("FAIL fill_set got=%0d want 4", fills); end
    do_op(4'd1, 12'h0AB, 4'd2, 2'd0, 2'd3, ok, h, ls, so);
    total++;
    if (!ok || {h, hit_way, ls} !== {1'b1, 2'd2, 3'd0}) begin
      bad++;
      $display("FAIL wr_hit_e ok=%b h=%b w=%0d ls=%0d want 1 1 2 0",
               ok, h, hit_way, ls);
    end
    send(4'd1, 12'h0CD, 4'd2, 2'd2);
    wait_bus(ok);
    total++;
    if (!ok || {bus_op, bus_tag, bus_index} !==
        {3'd2, 12'h0AB, 4'd2}) begin
      bad++;
      $display("FAIL evict_wr ok=%b op=%0d t=%h i=%0d want 1 2 0ab 2",
               ok, bus_op, bus_tag, bus_index);
    end
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    total++;
    if ({bus_valid, bus_op, bus_tag, bus_index} !==
        {1'b1, 3'd4, 12'h0CD, 4'd2}) begin
      bad++;
      $display("FAIL evict_rfo v=%b op=%0d t=%h i=%0d want 1 4 0cd 2",
               bus_valid, bus_op, bus_tag, bus_index);
    end
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    wait_done(ok);
    total++;
    if (!ok || {hit, line_state, snoop_out} !== {1'b0, 3'd0, 2'd3})
      begin
      bad++;
      $display("FAIL wr_miss_done ok=%b h=%b ls=%0d so=%0d want 1 0 0 3",
               ok, hit, line_state, snoop_out);
    end
    do_op(4'd0, 12'h0CD, 4'd2, 2'd0, 2'd3, ok, h, ls, so);
    total++;
    if (!ok || {h, hit_way, ls} !== {1'b1, 2'd2, 3'd0}) begin
      bad++;
      $display("FAIL new_line ok=%b h=%b w=%0d ls=%0d want 1 1 2 0",
               ok, h, hit_way, ls);
    end
  endtask

  task automatic test_snoop_f();
    logic ok, h;
    logic [2:0] ls;
    logic [1:0] so;
    do_op(4'd0, 12'h055, 4'd3, 2'd0, 2'd0, ok, h, ls, so);
    total++;
    if (!ok || {h, ls} !== {1'b0, 3'd4})
      begin bad++; $display("FAIL make_f ls=%0d want 4", ls); end
    do_op(4'd4, 12'h055, 4'd3, 2'd0, 2'd3, ok, h, ls, so);
    total++;
    if (!ok || {h, ls, so} !== {1'b1, 3'd2, 2'd0}) begin
      bad++;
      $display("FAIL snp_rd_f h=%b ls=%0d so=%0d want 1 2 0", h, ls, so);
    end
    do_op(4'd6, 12'h055, 4'd3, 2'd0, 2'd3, ok, h, ls, so);
    total++;
    if (!ok || {h, ls, so} !== {1'b1, 3'd3, 2'd0}) begin
      bad++;
      $display("FAIL snp_rfo_s h=%b ls=%0d so=%0d want 1 3 0", h, ls, so);
    end
    do_op(4'd4, 12'h999, 4'd9, 2'd0, 2'd3, ok, h, ls, so);
    total++;
    if (!ok || {h, ls, so} !== {1'b0, 3'd3, 2'd3}) begin
      bad++;
      $display("FAIL snp_miss h=%b ls=%0d so=%0d want 0 3 3", h, ls, so);
    end
    do_op(4'd2, 12'h055, 4'd3, 2'd0, 2'd1, ok, h, ls, so);
    total++;
    if (!ok || {h, ls} !== {1'b0, 3'd4}) begin
      bad++;
      $display("FAIL refill_f h=%b ls=%0d want 0 4", h, ls);
    end
  endtask

  task automatic test_snoop_m_stall();
    logic ok, h, stable;
    logic [2:0] ls;
    logic [1:0] so;
    do_op(4'd1, 12'h077, 4'd4, 2'd0, 2'd3, ok, h, ls, so);
    total++;
    if (!ok || ls !== 3'd0)
      begin bad++; $display("FAIL make_m ls=%0d want 0", ls); end
    send(4'd4, 12'h077, 4'd4, 2'd0);
    wait_bus(ok);
    stable = ok;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) bus_ready = 1'b1;
      if ({bus_valid, bus_op, bus_tag, bus_index, done} !==
          {1'b1, 3'd2, 12'h077, 4'd4, 1'b0})
        stable = 1'b0;
      if (k < 5) tick();
    end
    total++;
    if (!stable)
      begin bad++; $display("FAIL stall_stable got=0 want=1"); end
    tick();
    bus_ready = 1'b0;
    wait_done(ok);
    total++;
    if (!ok || {hit, line_state, snoop_out} !== {1'b1, 3'd2, 2'd1})
      begin
      bad++;
      $display("FAIL snp_rd_m ok=%b h=%b ls=%0d so=%0d want 1 1 2 1",
               ok, hit, line_state, snoop_out);
    end
  endtask

  task automatic test_write_s_clear();
    logic ok, h, seen;
    logic [2:0] ls;
    logic [1:0] so;
    int n, at;
    do_op(4'd0, 12'h099, 4'd5, 2'd0, 2'd3, ok, h, ls, so);
    do_op(4'd4, 12'h099, 4'd5, 2'd0, 2'd3, ok, h, ls, so);
    total++;
    if (!ok || ls !== 3'd2)
      begin bad++; $display("FAIL make_s ls=%0d want 2", ls); end
    send(4'd1, 12'h099, 4'd5, 2'd0);
    wait_bus(ok);
    total++;
    if (!ok || {bus_op, bus_tag, bus_index} !==
        {3'd3, 12'h099, 4'd5}) begin
      bad++;
      $display("FAIL wr_s_inv op=%0d t=%h i=%0d want 3 099 5",
               bus_op, bus_tag, bus_index);
    end
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    wait_done(ok);
    total++;
    if (!ok || {hit, line_state} !== {1'b1, 3'd0}) begin
      bad++;
      $display("FAIL wr_s_done h=%b ls=%0d want 1 0", hit, line_state);
    end
    send(4'd8, 12'h000, 4'd0, 2'd0);
    n = 0; at = 0; seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (req_ready) break;
      n++;
      if (done) begin seen = 1'b1; at = n; end
      tick();
    end
    total++;
    if (n != 18 || !seen || at != 18) begin
      bad++;
      $display("FAIL clear_lat busy=%0d done_at=%0d want 18 18", n, at);
    end
    do_op(4'd0, 12'h099, 4'd5, 2'd0, 2'd3, ok, h, ls, so);
    total++;
    if (!ok || h !== 1'b0)
      begin bad++; $display("FAIL clr_s5 hit=%b want 0", h); end
    do_op(4'd0, 12'h0CD, 4'd2, 2'd0, 2'd3, ok, h, ls, so);
    total++;
    if (!ok || h !== 1'b0)
      begin bad++; $display("FAIL clr_s2 hit=%b want 0", h); end
  endtask

  task automatic test_reset_mid();
    logic ok, h, quiet;
    logic [2:0] ls;
    logic [1:0] so;
    do_op(4'd0, 12'h111, 4'd7, 2'd0, 2'd3, ok, h, ls, so);
    send(4'd1, 12'h0EE, 4'd6, 2'd0);
    wait_bus(ok);
    total++;
    if (!ok || bus_op !== 3'd4)
      begin bad++; $display("FAIL mid_rfo op=%0d want 4", bus_op); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({bus_valid, done, req_ready} !== 3'b001) begin
      bad++;
      $display("FAIL mid_rst v=%b d=%b r=%b want 0 0 1",
               bus_valid, done, req_ready);
    end
    quiet = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (done || bus_valid) quiet = 1'b0;
      tick();
    end
    total++;
    if (!quiet)
      begin bad++; $display("FAIL mid_quiet got=0 want=1"); end
    do_op(4'd0, 12'h111, 4'd7, 2'd0, 2'd3, ok, h, ls, so);
    total++;
    if (!ok || h !== 1'b0)
      begin bad++; $display("FAIL mid_inval hit=%b want 0", h); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = '0;
    req_tag = '0;
    req_index = '0;
    lru_way = '0;
    bus_ready = 1'b0;
    snoop_in = 2'd3;
    test_reset();
    test_read_miss();
    test_write_evict();
    test_snoop_f();
    test_snoop_m_stall();
    test_write_s_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mesif_ctrl.md
# mesif_ctrl

Parametrised MESIF coherence controller for a WAYS-way, 2^INDEX_BITS-set cache. It holds the tag and MESIF state of every line and accepts one trace operation at a time (ops 0–9). For each operation it performs the lookup, victim selection and dirty eviction, issues bus operations through a valid/ready handshake, and returns the snoop result. It sits between the trace front-end, the LRU block (victim hint) and the bus model, replacing the single-line state machine.

## Interface
- TAG_BITS, 12, tag width
- INDEX_BITS, 4, set index width; SETS = 2^INDEX_BITS
- WAYS, 4, associativity; WAY_BITS = $clog2(WAYS), minimum 1
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- req_valid / req_ready  in/out  1  operation handshake; transfer when both are high
- req_op  in  4  trace operation code
- req_tag  in  TAG_BITS  request tag
- req_index  in  INDEX_BITS  request set
- lru_way  in  WAY_BITS  LRU victim hint for req_index; sampled in LOOKUP
- bus_valid / bus_ready  out/in  1  bus operation handshake
- bus_op  out  3  bus operation: NOP 0, READ 1, WRITE 2, INVALIDATE 3, RFO 4
- bus_tag, bus_index  out  TAG_BITS, INDEX_BITS  bus address
- snoop_in  in  2  other caches' result for our READ/RFO; sampled at the bus transfer
- done  out  1  one-cycle completion pulse
- hit, hit_way  out  1, WAY_BITS  lookup result; valid with done
- line_state  out  3  final MESIF state of the addressed line; valid with done
- snoop_out  out  2  our snoop response: HIT 0, HITM 1, NOHIT 3; valid with done

## Operation
- State codes: M 0, E 1, S 2, I 3, F 4. A way hits when its tag matches and its state is not I.
- Victim on a miss: lowest-index invalid way; if there is none, lru_way.
- FSM: IDLE → LOOKUP → [EVICT] → [BUS] → DONE → IDLE; CLEAR is entered from LOOKUP on op 8.
- req_ready is high only in IDLE. The request is registered on the transfer.
- CPU read (0, 2):
  - Hit: no bus operation, state unchanged.
  - Miss: EVICT (WRITE of the victim's tag) if the victim is M, then READ.
  - After READ, snoop_in HIT or HITM → F; NOHIT → E. The new tag is written into the victim way.
- CPU write (1):
  - Hit in M: no bus operation.
  - Hit in E: → M, no bus operation.
  - Hit in S or F: INVALIDATE, then → M.
  - Miss: evict as for a read, RFO, then → M.
- Snoop read (4):
  - M: HITM, WRITE, → S.
  - E or F: HIT, → S.
  - S: HIT, stays S.
  - Miss: NOHIT.
- Snoop RFO (6):
  - M: HITM, WRITE, → I.
  - E, S or F: HIT, → I.
  - Miss: NOHIT.
- Snoop invalidate (3): S or F → I with HIT. M, E or miss: no change, NOHIT.
- Snoop write (5), print (9), reserved codes (7, 10–15): no state change, NOHIT, DONE.
- Clear (8): CLEAR walks sets 0..SETS-1 at one set per cycle, setting every way to I, then DONE. Tags are untouched.
- snoop_out is NOHIT for CPU ops.

## Timing
- Reset values: req_ready 1, bus_valid 0, bus_op 0, bus_tag 0, bus_index 0, done 0, hit 0, hit_way 0, line_state 3, snoop_out 3.
- Reset invalidates all lines in the same cycle.
- Reset mid-operation returns the FSM to IDLE, drops bus_valid, and suppresses done.
- LOOKUP takes 1 cycle, so a hit with no bus operation has done 2 cycles after the request transfer.
- bus_valid and all bus fields are held stable until bus_ready. Each bus transfer takes ≥1 cycle.
- EVICT and the fill are back-to-back: the next bus_valid may assert the cycle after the EVICT transfer.
- The state array is updated on the clock edge that enters DONE. A request accepted the cycle after done sees the updated state.
- Clear latency: done SETS+1 cycles after LOOKUP.

## Structure
- mesif_pkg holds the state, op, bus-op and snoop codes and a state enum typedef.
- Sub-module mesif_next_state: a combinational function from (op, current state, hit, snoop_in) to (next state, bus op, snoop_out).
- mesif_ctrl holds the arrays, victim selection, FSM and handshakes.

## Test plan
- Read miss to an empty set, snoop_in NOHIT → bus READ, way 0 → E, done with line_state 1.
- Write miss to a full set, lru_way 2 with way 2 in M (tag 0x0AB) → WRITE tag 0x0AB, then RFO, way 2 → M.
- Line in F, snoop read → snoop_out HIT, → S. Then snoop RFO → HIT, → I.
- Line in M, snoop read, bus_ready held low 5 cycles → bus_valid and fields stable for 6 cycles, then → S, HITM.
- Line in S, CPU write → INVALIDATE, → M. Then op 8 → req_ready low for SETS+2 cycles, all lines I.
- rst asserted during the RFO wait → bus_valid 0 next cycle, no done, all lines I.
